// File: rtl/pio_pkg.sv
// pio_pkg: shared FSM state encoding and PIO register addresses for the event sequencer.
package pio_pkg;
  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_MASK,
    S_RD_EDGE,
    S_CAP_EDGE,
    S_CLR_EDGE,
    S_RD_DATA,
    S_CAP_DATA,
    S_PUSH
  } state_t;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
endpackage

// File: rtl/pio_event_fifo.sv
// pio_event_fifo: first-word-fall-through event FIFO with sticky drop flag.
module pio_event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_overflow;
  logic             w_empty, w_full, w_pop, w_push;
  assign w_empty    = r_wr_ptr == r_rd_ptr;
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop      = i_pop && !w_empty;
  // a pop in the same cycle frees the slot the push lands in
  assign w_push     = i_push && (!w_full || w_pop);
  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_overflow = r_overflow;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr   <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_overflow <= r_overflow || (i_push && !w_push);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/pio_event_sequencer.sv
// pio_event_sequencer: services PIO edge interrupts over the PIO register bus and
// queues {edges, level} events for a downstream consumer.
module pio_event_sequencer
  import pio_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] INIT_MASK = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  input  logic             mask_wr,
  input  logic [WIDTH-1:0] mask_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_level,
  output logic             overflow,
  output logic             busy
);
  localparam logic [WIDTH-1:0] CLR_ALL = '1;
  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_edges, r_level, r_mask_val;
  logic               r_mask_pend;
  logic [2*WIDTH-1:0] w_head;
  logic               w_unused_rd;
  assign w_unused_rd = ^(pio_readdata >> WIDTH);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_INIT;
    else          r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:     w_next = S_IDLE;
      S_IDLE:     w_next = r_mask_pend ? S_MASK : pio_irq ? S_RD_EDGE : S_IDLE;
      S_MASK:     w_next = S_IDLE;
      S_RD_EDGE:  w_next = S_CAP_EDGE;
      S_CAP_EDGE: w_next = (pio_readdata[WIDTH-1:0] == '0) ? S_IDLE : S_CLR_EDGE;
      S_CLR_EDGE: w_next = S_RD_DATA;
      S_RD_DATA:  w_next = S_CAP_DATA;
      S_CAP_DATA: w_next = S_PUSH;
      S_PUSH:     w_next = S_IDLE;
      default:    w_next = S_INIT;
    endcase
  end
  // bus is held idle while reset is asserted even though the state already reads INIT
  always_comb begin
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_address    = ADDR_DATA;
    pio_writedata  = '0;
    if (reset_n) begin
      case (r_state)
        S_INIT: begin
          pio_chipselect = 1'b1;
          pio_write_n    = 1'b0;
          pio_address    = ADDR_MASK;
          pio_writedata  = 32'(INIT_MASK);
        end
        S_MASK: begin
          pio_chipselect = 1'b1;
          pio_write_n    = 1'b0;
          pio_address    = ADDR_MASK;
          pio_writedata  = 32'(r_mask_val);
        end
        S_RD_EDGE: begin
          pio_chipselect = 1'b1;
          pio_address    = ADDR_EDGE;
        end
        S_CLR_EDGE: begin
          pio_chipselect = 1'b1;
          pio_write_n    = 1'b0;
          pio_address    = ADDR_EDGE;
          pio_writedata  = 32'(CLR_ALL);
        end
        S_RD_DATA: begin
          pio_chipselect = 1'b1;
          pio_address    = ADDR_DATA;
        end
        default: ;
      endcase
    end
  end
  assign busy = r_state != S_IDLE;
  // a mask request arriving during the MASK write stays pending for the next pass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edges     <= '0;
      r_level     <= '0;
      r_mask_val  <= '0;
      r_mask_pend <= 1'b0;
    end else begin
      if (r_state == S_CAP_EDGE) r_edges <= pio_readdata[WIDTH-1:0];
      if (r_state == S_CAP_DATA) r_level <= pio_readdata[WIDTH-1:0];
      if (mask_wr) begin
        r_mask_pend <= 1'b1;
        r_mask_val  <= mask_data;
      end else if (r_state == S_MASK) begin
        r_mask_pend <= 1'b0;
      end
    end
  end
  pio_event_fifo #(
    .WIDTH(2*WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (r_state == S_PUSH),
    .i_data    ({r_edges, r_level}),
    .i_pop     (evt_ready),
    .o_data    (w_head),
    .o_valid   (evt_valid),
    .o_overflow(overflow)
  );
  assign evt_edges = w_head[2*WIDTH-1:WIDTH];
  assign evt_level = w_head[WIDTH-1:0];
endmodule

// File: tb/tb_pio_event_sequencer.sv
// tb_pio_event_sequencer: PIO register model plus event-queue reference model,
// random switch toggles and directed corner cases.
module tb_pio_event_sequencer;
  localparam int W = 8;
  localparam int D = 4;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   pio_address;
  logic         pio_chipselect, pio_write_n;
  logic [31:0]  pio_writedata;
  logic [31:0]  pio_readdata = '0;
  logic         pio_irq;
  logic         mask_wr = 1'b0;
  logic [W-1:0] mask_data = '0;
  logic         evt_valid, evt_ready = 1'b0, overflow, busy;
  logic [W-1:0] evt_edges, evt_level;
  always #5 clk = ~clk;
  pio_event_sequencer #(.WIDTH(W), .DEPTH(D), .INIT_MASK(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata), .pio_readdata(pio_readdata),
    .pio_irq(pio_irq), .mask_wr(mask_wr), .mask_data(mask_data), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_edges(evt_edges), .evt_level(evt_level), .overflow(overflow), .busy(busy)
  );
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // PIO peripheral: switch inputs, edge capture, irq mask, registered read data
  logic [W-1:0]  sw = '0, sw_q = '0, edge_r = '0, mask_r = '0;
  logic          force_irq = 1'b0;
  logic [34:0]   acc[$];
  assign pio_irq = (|(edge_r & mask_r)) | force_irq;
  always @(posedge clk) begin
    sw_q   <= sw;
    edge_r <= ((pio_chipselect && !pio_write_n && pio_address == 2'd3) ? '0 : edge_r) | (sw ^ sw_q);
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2) mask_r <= pio_writedata[W-1:0];
    if (pio_chipselect && pio_write_n)
      pio_readdata <= pio_address == 2'd0 ? 32'(sw) : pio_address == 2'd2 ? 32'(mask_r) :
                      pio_address == 2'd3 ? 32'(edge_r) : 32'd0;
    if (pio_chipselect) acc.push_back({!pio_write_n, pio_address, pio_writedata});
  end
  function automatic logic [2:0] kind(input int i);
    logic [34:0] e;
    e = acc[i];
    return e[34:32];
  endfunction
  // reference: bounded queue of expected events and sticky drop flag
  logic [2*W-1:0] exp_q[$];
  logic           exp_ovf = 1'b0;
  function automatic void model_push(input logic [2*W-1:0] e);
    if (exp_q.size() < D) exp_q.push_back(e);
    else exp_ovf = 1'b1;
  endfunction
  always @(negedge clk) begin
    if (reset_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", evt_valid, 1'b0);
      else chk("pop_entry", {evt_edges, evt_level}, exp_q.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_busy(input logic v, input string tag);
    int n;
    n = 0;
    while (busy !== v && n < 40) begin
      tick();
      n++;
    end
    if (busy !== v) chk(tag, busy, v);
  endtask
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!evt_valid && n < 40) begin
      tick();
      n++;
    end
    if (!evt_valid) chk(tag, evt_valid, 1'b1);
  endtask
  task automatic do_event(input logic [W-1:0] t);
    sw = sw ^ t;
    wait_busy(1'b1, "svc_start");
    wait_busy(1'b0, "svc_end");
    model_push({t, sw});
  endtask
  task automatic drain_all();
    int n;
    n = 0;
    evt_ready = 1'b1;
    while (evt_valid && n < 20) begin
      tick();
      n++;
    end
    evt_ready = 1'b0;
    chk("drained", evt_valid, 1'b0);
    chk("model_empty", exp_q.size(), 0);
  endtask
  function automatic logic [W-1:0] rnd_nz();
    return W'($urandom_range(1, (1 << W) - 1));
  endfunction
  initial begin
    int mark, n;
    logic [W-1:0] t;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cs", pio_chipselect, 1'b0);
    chk("rst_wn", pio_write_n, 1'b1);
    chk("rst_addr", pio_address, 2'd0);
    chk("rst_wdata", pio_writedata, 32'd0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_head", {evt_edges, evt_level}, 16'd0);
    chk("rst_ovf", overflow, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("init_access", {pio_chipselect, pio_write_n, pio_address}, {1'b1, 1'b0, 2'd2});
    chk("init_data", pio_writedata, 32'h0000_00FF);
    tick();
    chk("init_busy_low", busy, 1'b0);
    chk("init_pio_mask", mask_r, 8'hFF);
    // switch 3 toggles: read edge, clear edge, read data, push after fixed latency
    mark = acc.size();
    sw = sw ^ 8'h08;
    wait_busy(1'b1, "s3_start");
    n = 0;
    while (!evt_valid && n < 20) begin
      tick();
      n++;
    end
    chk("s3_latency", n, 6);
    wait_busy(1'b0, "s3_end");
    model_push({8'h08, sw});
    chk("s3_naccess", acc.size() - mark, 3);
    chk("s3_acc0", kind(mark), 3'b0_11);
    chk("s3_acc1", kind(mark + 1), 3'b1_11);
    chk("s3_acc2", kind(mark + 2), 3'b0_00);
    chk("s3_head", {evt_edges, evt_level}, 16'h0808);
    chk("s3_pio_edge_clr", edge_r, 8'h00);
    drain_all();
    // spurious irq: edge register reads zero
    mark = acc.size();
    force_irq = 1'b1;
    tick();
    force_irq = 1'b0;
    repeat (6) tick();
    chk("spur_naccess", acc.size() - mark, 1);
    chk("spur_acc0", kind(mark), 3'b0_11);
    chk("spur_busy", busy, 1'b0);
    chk("spur_valid", evt_valid, 1'b0);
    // fill, then push on full with a pop in the PUSH cycle
    for (int i = 0; i < D; i++) do_event(rnd_nz());
    chk("full_valid", evt_valid, 1'b1);
    chk("full_ovf", overflow, 1'b0);
    t = rnd_nz();
    sw = sw ^ t;
    repeat (7) tick();
    chk("simul_push_busy", busy, 1'b1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    wait_busy(1'b0, "simul_end");
    model_push({t, sw});
    chk("simul_ovf", overflow, 1'b0);
    do_event(rnd_nz());
    chk("drop_ovf", overflow, exp_ovf);
    chk("drop_exp", exp_ovf, 1'b1);
    drain_all();
    chk("ovf_sticky", overflow, 1'b1);
    // mask request during service lands right after PUSH
    mark = acc.size();
    sw = sw ^ 8'h01;
    wait_busy(1'b1, "mask_start");
    repeat (2) tick();
    mask_wr = 1'b1;
    mask_data = 8'h0F;
    tick();
    mask_wr = 1'b0;
    wait_busy(1'b0, "mask_svc_end");
    repeat (4) tick();
    model_push({8'h01, sw});
    chk("mask_naccess", acc.size() - mark, 4);
    chk("mask_write", acc[mark + 3], {1'b1, 2'd2, 32'h0000_000F});
    chk("mask_pio", mask_r, 8'h0F);
    drain_all();
    mark = acc.size();
    sw = sw ^ 8'h80;
    repeat (8) tick();
    chk("masked_noirq", acc.size() - mark, 0);
    mask_wr = 1'b1;
    mask_data = 8'hFF;
    tick();
    mask_wr = 1'b0;
    wait_valid("unmask_evt");
    wait_busy(1'b0, "unmask_end");
    model_push({8'h80, sw});
    chk("unmask_write", acc[mark], {1'b1, 2'd2, 32'h0000_00FF});
    drain_all();
    // reset while the edge-clear write is on the bus
    t = rnd_nz();
    sw = sw ^ t;
    n = 0;
    while (!(pio_chipselect && !pio_write_n && pio_address == 2'd3) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("clr_seen", n, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_cs", pio_chipselect, 1'b0);
    chk("mid_wn", pio_write_n, 1'b1);
    chk("mid_addr", pio_address, 2'd0);
    chk("mid_wdata", pio_writedata, 32'd0);
    chk("mid_busy", busy, 1'b1);
    exp_q.delete();
    exp_ovf = 1'b0;
    tick();
    chk("mid_ovf", overflow, 1'b0);
    chk("mid_valid", evt_valid, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("reinit_access", {pio_chipselect, pio_write_n, pio_address}, {1'b1, 1'b0, 2'd2});
    chk("reinit_data", pio_writedata, 32'h0000_00FF);
    wait_valid("reinit_evt");
    wait_busy(1'b0, "reinit_end");
    model_push({t, sw});
    drain_all();
    // random toggles with random consumer readiness between services
    for (int i = 0; i < 24; i++) begin
      evt_ready = 1'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      evt_ready = 1'b0;
      do_event(rnd_nz());
      chk("rnd_ovf", overflow, exp_ovf);
      chk("rnd_valid", evt_valid, exp_q.size() != 0);
    end
    drain_all();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pio_event_sequencer.md
PIO_EVENT_SEQUENCER -- requirements
Module: pio_event_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, 8, PIO data/edge/mask width.
REQ-002 SHALL have parameter DEPTH, 4, event FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter INIT_MASK, all-ones, irq_mask value written after reset.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pio_address  output  2  PIO register select (0 data, 2 mask, 3 edge).
REQ-007 SHALL have port pio_chipselect  output  1  PIO access strobe, one cycle per access.
REQ-008 SHALL have port pio_write_n  output  1  low = write access.
REQ-009 SHALL have port pio_writedata  output  32  write data, upper 32-WIDTH bits zero.
REQ-010 SHALL have port pio_readdata  input  32  PIO read data, registered, valid the cycle after the access.
REQ-011 SHALL have port pio_irq  input  1  PIO interrupt.
REQ-012 SHALL have port mask_wr  input  1  single-cycle request to reprogram irq_mask.
REQ-013 SHALL have port mask_data  input  WIDTH  new mask, sampled with mask_wr.
REQ-014 SHALL have port evt_valid  output  1  FIFO non-empty.
REQ-015 SHALL have port evt_ready  input  1  consumer accepts head entry when high with evt_valid.
REQ-016 SHALL have port evt_edges  output  WIDTH  edge bits of head entry.
REQ-017 SHALL have port evt_level  output  WIDTH  switch levels of head entry.
REQ-018 SHALL have port overflow  output  1  sticky: an event was dropped on full FIFO.
REQ-019 SHALL have port busy  output  1  FSM not in IDLE.

Function
REQ-020 FSM states SHALL be INIT, IDLE, MASK, RD_EDGE, CAP_EDGE, CLR_EDGE, RD_DATA, CAP_DATA, PUSH.
REQ-021 INIT: one write of INIT_MASK to address 2, then IDLE.
REQ-022 mask_wr SHALL latch mask_data into a pending register in any state; newer request overwrites older.
REQ-023 IDLE priority: pending mask -> MASK (write address 2, clear pending, -> IDLE); else pio_irq -> RD_EDGE; else stay.
REQ-024 RD_EDGE: read address 3; CAP_EDGE: capture pio_readdata[WIDTH-1:0] as edges.
REQ-025 CAP_EDGE with edges==0 (spurious irq) SHALL return to IDLE without write or push.
REQ-026 CLR_EDGE: write address 3 (clears all edge bits); RD_DATA: read address 0; CAP_DATA: capture level.
REQ-027 PUSH: enqueue {edges, level} if FIFO not full, else drop and set overflow; -> IDLE in one cycle.
REQ-028 Service latency irq-sampled-in-IDLE to evt_valid SHALL be 7 cycles with empty FIFO.
REQ-029 Outside access states pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
REQ-030 FIFO SHALL be first-word-fall-through; push and pop in the same cycle on a full FIFO: pop occurs, push is accepted, no overflow.
REQ-031 Read/write pointers SHALL be log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full/empty from MSB compare.
REQ-032 overflow SHALL clear only on reset.
REQ-033 Edges arriving between CAP_EDGE and CLR_EDGE are lost; this is the defined behaviour.

Reset
REQ-034 Reset SHALL force state INIT, FIFO empty, overflow=0, pending mask cleared, all PIO outputs to idle values of REQ-029.
REQ-035 evt_valid, busy(=1 in INIT), evt_edges=0, evt_level=0 SHALL hold during and immediately after reset; in-flight sequence abandoned.

Structure
REQ-036 State encoding and register address constants (DATA=0, MASK=2, EDGE=3) SHALL live in shared package pio_pkg.
REQ-037 FIFO SHALL be sub-module pio_event_fifo.

Verification
REQ-038 Reset release -> write 0xFF to address 2 on first access cycle, busy low within 2 cycles.
REQ-039 Switch 3 toggles, PIO irq -> read 3 returns 0x08, write 3, read 0 returns 0x08; entry {0x08,0x08} valid 7 cycles later.
REQ-040 irq with edge read 0x00 -> no write, no push, back to IDLE.
REQ-041 evt_ready=0, 5 events -> 4 entries queued, overflow=1; drain shows order preserved.
REQ-042 mask_wr 0x0F during service -> write 0x0F to address 2 immediately after PUSH, before next irq.
REQ-043 reset_n low mid CLR_EDGE -> outputs idle at once, INIT mask write after release.
